// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, instruction memory address, IF/ID register
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-low reset
//   Stall, Flush               hazard-unit hold of PC+IF/ID, squash of IF/ID
//   BranchTaken, BranchTarget  resolved taken branch and its byte address
//   Jump, JumpTarget           decoded jump and its byte address
//   ImemAddress                byte address to instruction memory (= PC)
//   ImemInstruction            combinational word from instruction memory
//   IF_ID_Instruction          registered instruction
//   IF_ID_PCPlus4              registered PC+4 of that instruction
//   IF_ID_Valid                IF/ID holds a real instruction
//   Halted                     fetch frozen by a halt word
//   MisalignErr                sticky: a redirect target had nonzero low bits
//   FetchCount                 valid instructions latched into IF/ID

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic        MisalignErr,
    output logic [31:0] FetchCount
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] pc_plus4;

    assign redirect   = BranchTaken | Jump;
    // The branch is the older instruction, so it wins over a same-cycle jump.
    assign target_raw = BranchTaken ? BranchTarget : JumpTarget;
    assign pc_plus4   = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        if (redirect) begin
            pc_d    = {target_raw[31:2], 2'b00};
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            state_d = ST_RUN;
            if (target_raw[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (Stall) begin
            if (Flush) begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end
        end else if (state_q == ST_HALTED) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (Flush) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            pc_d    = pc_plus4;
        end else begin
            instr_d = ImemInstruction;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
            // The halt word itself is delivered downstream; fetch then parks on it.
            if (ImemInstruction == HALT_WORD) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign ImemAddress       = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pc4_q;
    assign IF_ID_Valid       = valid_q;
    assign Halted            = (state_q == ST_HALTED);
    assign MisalignErr       = misalign_q;
    assign FetchCount        = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard testbench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic        MisalignErr;
    logic [31:0] FetchCount;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        misalign;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    instruction_fetch_unit dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .ImemAddress      (ImemAddress),
        .ImemInstruction  (ImemInstruction),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .Halted           (Halted),
        .MisalignErr      (MisalignErr),
        .FetchCount       (FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign ImemInstruction = mem[ImemAddress[7:2]];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid, input logic halted,
                                input logic misalign, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.pc4 = pc4;
        e.valid = valid; e.halted = halted; e.misalign = misalign; e.cnt = cnt;
        return e;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".pc"},       ImemAddress,        e.pc);
        check({e.tag, ".instr"},    IF_ID_Instruction,  e.instr);
        check({e.tag, ".valid"},    {31'd0, IF_ID_Valid}, {31'd0, e.valid});
        if (e.valid) begin
            check({e.tag, ".pc4"},  IF_ID_PCPlus4,      e.pc4);
        end
        check({e.tag, ".halted"},   {31'd0, Halted},      {31'd0, e.halted});
        check({e.tag, ".misalign"}, {31'd0, MisalignErr}, {31'd0, e.misalign});
        check({e.tag, ".cnt"},      FetchCount,         e.cnt);
    endtask

    // Called at a falling edge: drive inputs, push expectation, clock once, compare.
    task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input exp_t e);
        Stall = st; Flush = fl; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
        sb.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        compare_front();
    endtask

    task automatic run(input exp_t e);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc"},       ImemAddress,                 32'h0000_0000);
        check({tag, ".instr"},    IF_ID_Instruction,           32'h0000_0000);
        check({tag, ".pc4"},      IF_ID_PCPlus4,               32'h0000_0000);
        check({tag, ".valid"},    {31'd0, IF_ID_Valid},        32'd0);
        check({tag, ".halted"},   {31'd0, Halted},             32'd0);
        check({tag, ".misalign"}, {31'd0, MisalignErr},        32'd0);
        check({tag, ".cnt"},      FetchCount,                  32'd0);
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        BranchTaken = 1'b0; BranchTarget = 32'd0; Jump = 1'b0; JumpTarget = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h2008_0001;
        mem[1]  = 32'h2009_0002;
        mem[2]  = 32'h0109_5020;
        mem[3]  = 32'h0000_0000;
        mem[8]  = 32'h8C0B_0004;
        mem[10] = 32'h014B_6020;
        mem[16] = 32'h2010_0010;
        mem[63] = 32'h2402_0007;

        #2;
        check_reset_outputs("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // sequential fetch, then a 2-cycle stall at PC=8, then resume
        run(mk("seq0", 32'h04, 32'h2008_0001, 32'h04, 1, 0, 0, 1));
        run(mk("seq1", 32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 2));
        step(1, 0, 0, 0, 0, 0, mk("stall0", 32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 2));
        step(1, 0, 0, 0, 0, 0, mk("stall1", 32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 2));
        run(mk("seq2", 32'h0C, 32'h0109_5020, 32'h0C, 1, 0, 0, 3));

        // branch beats simultaneous jump and stall
        step(1, 0, 1, 32'h40, 1, 32'h80, mk("br_jmp", 32'h40, 32'h0, 32'h0, 0, 0, 0, 3));
        run(mk("br_tgt", 32'h44, 32'h2010_0010, 32'h44, 1, 0, 0, 4));

        // halt word at 0x0C, then jump out of HALTED
        mem[3] = 32'hFC00_0000;
        step(0, 0, 0, 0, 1, 32'h0C, mk("j_halt", 32'h0C, 32'h0, 32'h0, 0, 0, 0, 4));
        run(mk("halt_lat", 32'h0C, 32'hFC00_0000, 32'h10, 1, 1, 0, 5));
        run(mk("halted0",  32'h0C, 32'h0, 32'h0, 0, 1, 0, 5));
        run(mk("halted1",  32'h0C, 32'h0, 32'h0, 0, 1, 0, 5));
        step(0, 0, 0, 0, 1, 32'h20, mk("unhalt", 32'h20, 32'h0, 32'h0, 0, 0, 0, 5));
        run(mk("after_uh", 32'h24, 32'h8C0B_0004, 32'h24, 1, 0, 0, 6));

        // flush in run, flush under stall, then normal
        step(0, 1, 0, 0, 0, 0, mk("flush",    32'h28, 32'h0, 32'h0, 0, 0, 0, 6));
        step(1, 1, 0, 0, 0, 0, mk("st_flush", 32'h28, 32'h0, 32'h0, 0, 0, 0, 6));
        run(mk("post_fl", 32'h2C, 32'h014B_6020, 32'h2C, 1, 0, 0, 7));

        // misaligned branch target
        step(0, 0, 1, 32'h43, 0, 0, mk("misal", 32'h40, 32'h0, 32'h0, 0, 0, 1, 7));
        run(mk("misal_st", 32'h44, 32'h2010_0010, 32'h44, 1, 0, 1, 8));

        // asynchronous reset between edges
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge Clk);
        Reset = 1'b1;

        // PC wrap from 0xFFFF_FFFC
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, mk("j_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0));
        run(mk("wrap", 32'h0000_0000, 32'h2402_0007, 32'h0000_0000, 1, 0, 0, 1));

        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
